// File: rtl/mac_seq_neuron.sv
// mac_seq_neuron: streams x/w pairs into a wide accumulator seeded with the bias,
// then rescales, saturates or wraps, and holds the result until it is consumed.
module mac_seq_neuron #(
    parameter int SIGN_BIT   = 1,
    parameter int INTE_WIDTH = 1,
    parameter int FRAC_WIDTH = 2,
    parameter int N_INPUTS   = 4,
    parameter int GUARD_BITS = 4,
    parameter int SATURATE   = 1,
    localparam int W     = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH,
    localparam int ACC_W = 2 * W + GUARD_BITS,
    localparam int CNT_W = $clog2(N_INPUTS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic        [W-1:0] result,
    output logic                overflow,
    output logic                busy
);
    localparam int SW = ACC_W - FRAC_WIDTH;
    localparam logic signed [SW-1:0] S_MAX = SW'(2 ** (W - 1) - 1);
    localparam logic signed [SW-1:0] S_MIN = SW'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, sum;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic        [W-1:0]       res_q, res_d, res_sat;
    logic                      ovf_q, ovf_d;
    logic signed [2*W-1:0]     prod;
    logic signed [SW-1:0]      s;
    logic                      hi, lo, last;

    // Rescale is taken from the post-beat sum so the result lands on the last-beat edge.
    always_comb begin
        prod    = x * w;
        sum     = acc_q + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
        s       = sum[ACC_W-1:FRAC_WIDTH];
        hi      = s > S_MAX;
        lo      = s < S_MIN;
        res_sat = (SATURATE != 0) ? (hi ? {1'b0, {(W - 1){1'b1}}} :
                                     lo ? {1'b1, {(W - 1){1'b0}}} : s[W-1:0]) : s[W-1:0];
        last    = cnt_q == CNT_W'(N_INPUTS - 1);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = {{(ACC_W - W){bias[W-1]}}, bias} << FRAC_WIDTH;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: if (in_valid) begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    res_d   = res_sat;
                    ovf_d   = hi | lo;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign result    = res_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_mac_seq_neuron.sv
// tb_mac_seq_neuron: scoreboard bench for a saturating and a wrapping neuron fed identical stimulus.
module tb_mac_seq_neuron;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
    logic [3:0] bias = 0, x = 0, w = 0;
    logic in_ready, out_valid, overflow, busy;
    logic in_ready_w, out_valid_w, overflow_w, busy_w;
    logic [3:0] result, result_w;
    int compared = 0, mismatched = 0, cyc = 0, lat;

    typedef struct {int r; int o;} exp_t;
    exp_t sq[$], wq[$];

    mac_seq_neuron #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .busy(busy));

    mac_seq_neuron #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(in_ready_w),
        .x(x), .w(w), .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
        .overflow(overflow_w), .busy(busy_w));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int a, input int e);
        compared++;
        if (a != e) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sq.size() == 0) chk("sat_unexpected_output", 1, 0);
            else begin
                e = sq.pop_front();
                chk("sat_result", int'($signed(result)), e.r);
                chk("sat_overflow", int'(overflow), e.o);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid_w && out_ready) begin
            if (wq.size() == 0) chk("wrap_unexpected_output", 1, 0);
            else begin
                e = wq.pop_front();
                chk("wrap_result", int'($signed(result_w)), e.r);
                chk("wrap_overflow", int'(overflow_w), e.o);
            end
        end
    end

    // Called #1 after a clock edge; returns cycles from the start cycle to the first valid cycle inclusive.
    task automatic run(input int b, input int xv[4], input int wv[4],
                       input int er, input int eo, input int ewr, input int ewo, output int l);
        int t0, n;
        sq.push_back('{er, eo});
        wq.push_back('{ewr, ewo});
        start = 1;
        bias = 4'(b);
        @(posedge clk); #1;
        start = 0;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            x = 4'(xv[i]);
            w = 4'(wv[i]);
            @(posedge clk); #1;
        end
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_before_timeout", int'(out_valid), 1);
        l = cyc - t0 + 2;
        @(posedge clk); #1;
        chk("idle_after_handshake", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 0;
        @(posedge clk); #1;

        run(0, '{2, 2, 2, 2}, '{2, 2, 2, 2}, 4, 0, 4, 0, lat);
        chk("t1_latency", lat, 6);
        run(1, '{4, 4, 4, 4}, '{4, 4, 4, 4}, 7, 1, 1, 1, lat);
        run(0, '{-4, -4, -4, -4}, '{2, 2, 2, 2}, -8, 0, -8, 0, lat);
        run(0, '{-4, -4, -4, -4}, '{-4, -4, -4, -4}, 7, 1, 0, 1, lat);
        run(0, '{-1, -1, -1, 0}, '{1, 1, 1, 1}, -1, 0, -1, 0, lat);
        run(0, '{1, 1, 1, 0}, '{1, 1, 1, 1}, 0, 0, 0, 0, lat);
        run(-2, '{-4, -4, -4, -4}, '{4, 4, 4, 4}, -8, 1, -2, 1, lat);
        run(0, '{7, 7, 7, 7}, '{1, 1, 1, 1}, 7, 0, 7, 0, lat);

        // Handshake: gapped beats, stray start, stalled consumer, junk input while DONE.
        sq.push_back('{2, 0});
        wq.push_back('{2, 0});
        out_ready = 0;
        start = 1;
        bias = 0;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1;
            x = (k == 3) ? 4'hF : 4'(k + 1);
            w = 4'd2;
            start = (k == 1);
            @(posedge clk); #1;
            in_valid = 0;
            x = 4'd7;
            w = 4'd7;
            start = 0;
            @(posedge clk); #1;
        end
        in_valid = 1;
        start = 1;
        for (int j = 0; j < 5; j++) begin
            chk("t5_hold_valid", int'(out_valid), 1);
            chk("t5_hold_result", int'($signed(result)), 2);
            chk("t5_hold_in_ready", int'(in_ready), 0);
            chk("t5_hold_busy", int'(busy), 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        start = 0;
        out_ready = 1;
        @(posedge clk); #1;
        chk("t5_released", int'(out_valid), 0);
        run(1, '{3, 3, 3, 3}, '{3, 3, 3, 3}, 7, 1, -6, 1, lat);

        // Reset in the middle of accumulation.
        start = 1;
        bias = 0;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1;
        x = 4'd4;
        w = 4'd4;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_in_ready", int'(in_ready), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_result", int'(result), 0);
        chk("t6_overflow", int'(overflow), 0);
        in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("t6_still_idle", int'(busy), 0);
        run(0, '{2, 2, 2, 2}, '{2, 2, 2, 2}, 4, 0, 4, 0, lat);
        chk("t6_latency", lat, 6);

        repeat (3) @(posedge clk);
        chk("sat_scoreboard_drained", sq.size(), 0);
        chk("wrap_scoreboard_drained", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
